// File: rtl/cache_bus_pkg.sv
// Shared cache/memory bus types: memory command encoding, transfer-engine
// state encoding and default line geometry.
package cache_bus_pkg;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_LINE_BYTES = 16;
    localparam int DEF_BUS_W      = 16;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WBEAT = 3'd2,
        ST_WACK  = 3'd3,
        ST_RBEAT = 3'd4,
        ST_RESP  = 3'd5
    } xfer_state_e;

    function automatic int beat_count(input int line_bytes, input int bus_w);
        return (line_bytes * 8) / bus_w;
    endfunction

    function automatic int beat_idx_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/line_beat_reg.sv
// Line-wide holding register: whole-line load, beat-indexed write for read
// assembly and beat-indexed select for write serialization.
module line_beat_reg
    import cache_bus_pkg::*;
#(
    parameter int LINE_BITS = DEF_LINE_BYTES * 8,
    parameter int BUS_W     = DEF_BUS_W,
    parameter int BEATS     = LINE_BITS / BUS_W,
    parameter int IDX_W     = beat_idx_width(BEATS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [LINE_BITS-1:0] load_line_i,
    input  logic                 beat_we_i,
    input  logic [IDX_W-1:0]     beat_widx_i,
    input  logic [BUS_W-1:0]     beat_wdata_i,
    input  logic [IDX_W-1:0]     beat_ridx_i,
    output logic [BUS_W-1:0]     beat_rdata_o,
    output logic [LINE_BITS-1:0] line_next_o
);

    logic [LINE_BITS-1:0] line_q;
    logic [LINE_BITS-1:0] line_d;

    // line_next_o exposes the line including a beat being written this cycle,
    // so the final read beat can be captured into the response in one edge.
    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = load_line_i;
        end else if (beat_we_i) begin
            for (int k = 0; k < BEATS; k++) begin
                if (beat_widx_i == IDX_W'(k)) begin
                    line_d[k*BUS_W +: BUS_W] = beat_wdata_i;
                end
            end
        end
    end

    always_comb begin
        beat_rdata_o = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_ridx_i == IDX_W'(k)) begin
                beat_rdata_o = line_q[k*BUS_W +: BUS_W];
            end
        end
    end

    assign line_next_o = line_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/line_xfer_engine.sv
// Cache-line transfer engine: turns single whole-line requests into a memory
// command plus a fixed-length beat burst, and returns one completion pulse.
module line_xfer_engine
    import cache_bus_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int BUS_W      = DEF_BUS_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [LINE_BYTES*8-1:0]     req_wdata,
    output logic                        resp_valid,
    output logic                        resp_write,
    output logic [LINE_BYTES*8-1:0]     resp_rdata,
    output logic [1:0]                  mem_cmd,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_wvalid,
    output logic [BUS_W-1:0]            mem_wdata,
    input  logic                        mem_rvalid,
    input  logic [BUS_W-1:0]            mem_rdata,
    input  logic                        mem_ack,
    output logic                        protocol_err
);

    localparam int LINE_BITS = LINE_BYTES * 8;
    localparam int BEATS     = beat_count(LINE_BYTES, BUS_W);
    localparam int CNT_W     = beat_idx_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    xfer_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 write_q;
    mem_cmd_e             mem_cmd_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic                 mem_wvalid_q;
    logic [BUS_W-1:0]     mem_wdata_q;
    logic                 resp_valid_q;
    logic                 resp_write_q;
    logic [LINE_BITS-1:0] resp_rdata_q;
    logic                 protocol_err_q;

    logic                 accept;
    logic                 beat_we;
    logic [CNT_W-1:0]     beat_ridx;
    logic [BUS_W-1:0]     beat_sel;
    logic [LINE_BITS-1:0] line_next;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_ready && req_valid;
    assign beat_we   = (state_q == ST_RBEAT) && mem_rvalid;

    // Write data is registered one beat ahead: CMD preloads beat 0, and each
    // WBEAT cycle preloads the beat after the one currently on the bus.
    assign beat_ridx = (state_q == ST_CMD) ? '0 : cnt_q + CNT_W'(1);

    line_beat_reg #(
        .LINE_BITS (LINE_BITS),
        .BUS_W     (BUS_W),
        .BEATS     (BEATS),
        .IDX_W     (CNT_W)
    ) u_line (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (accept),
        .load_line_i  (req_wdata),
        .beat_we_i    (beat_we),
        .beat_widx_i  (cnt_q),
        .beat_wdata_i (mem_rdata),
        .beat_ridx_i  (beat_ridx),
        .beat_rdata_o (beat_sel),
        .line_next_o  (line_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            write_q        <= 1'b0;
            mem_cmd_q      <= MEM_NOP;
            mem_addr_q     <= '0;
            mem_wvalid_q   <= 1'b0;
            mem_wdata_q    <= '0;
            resp_valid_q   <= 1'b0;
            resp_write_q   <= 1'b0;
            resp_rdata_q   <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            // Stray read beats or acks are flagged but otherwise ignored.
            if ((mem_rvalid && state_q != ST_RBEAT) || (mem_ack && state_q != ST_WACK)) begin
                protocol_err_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        cnt_q      <= '0;
                        mem_cmd_q  <= req_write ? MEM_WRITE : MEM_READ;
                        mem_addr_q <= req_addr;
                        state_q    <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    mem_cmd_q  <= MEM_NOP;
                    mem_addr_q <= '0;
                    if (write_q) begin
                        mem_wvalid_q <= 1'b1;
                        mem_wdata_q  <= beat_sel;
                        state_q      <= ST_WBEAT;
                    end else begin
                        state_q <= ST_RBEAT;
                    end
                end
                ST_WBEAT: begin
                    if (cnt_q == LAST_BEAT) begin
                        mem_wvalid_q <= 1'b0;
                        mem_wdata_q  <= '0;
                        state_q      <= ST_WACK;
                    end else begin
                        cnt_q       <= cnt_q + CNT_W'(1);
                        mem_wdata_q <= beat_sel;
                    end
                end
                ST_WACK: begin
                    if (mem_ack) begin
                        resp_valid_q <= 1'b1;
                        resp_write_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RBEAT: begin
                    if (mem_rvalid) begin
                        if (cnt_q == LAST_BEAT) begin
                            resp_valid_q <= 1'b1;
                            resp_write_q <= 1'b0;
                            resp_rdata_q <= line_next;
                            state_q      <= ST_RESP;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_write_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_cmd      = mem_cmd_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wvalid   = mem_wvalid_q;
    assign mem_wdata    = mem_wdata_q;
    assign resp_valid   = resp_valid_q;
    assign resp_write   = resp_write_q;
    assign resp_rdata   = resp_rdata_q;
    assign protocol_err = protocol_err_q;

endmodule
